// File: rtl/tag_lookup_ctrl_pkg.sv
// Shared cache definitions: lookup FSM encodings and default geometry.
// The cache top and the fill controller import these as well.
package tag_lookup_ctrl_pkg;

  localparam int unsigned DEF_WAYS  = 4;
  localparam int unsigned DEF_SETS  = 16;
  localparam int unsigned DEF_TAG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CMP  = 2'd2,
    ST_RESP = 2'd3
  } lookup_state_e;

endpackage

// File: rtl/tag_comparator.sv
// Single TAG_W-bit equality comparator, shared by every way of a lookup.
module tag_comparator #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  // Pure combinational equality
  assign eq = (a == b);

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Tag lookup sequencer: walks the ways of one set through a 1-cycle tag
// store read port, reports hit/way or miss/victim (first invalid way,
// otherwise the set's round-robin pointer).
module tag_lookup_ctrl
  import tag_lookup_ctrl_pkg::*;
#(
  parameter  int unsigned WAYS  = DEF_WAYS,
  parameter  int unsigned SETS  = DEF_SETS,
  parameter  int unsigned TAG_W = DEF_TAG_W,
  localparam int unsigned WAY_W = $clog2(WAYS),
  localparam int unsigned IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  output logic             tag_rd_en,
  output logic [IDX_W-1:0] tag_rd_index,
  output logic [WAY_W-1:0] tag_rd_way,
  input  logic [TAG_W-1:0] tag_rd_tag,
  input  logic             tag_rd_vld,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way
);

  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  lookup_state_e    r_state, w_state_n;
  logic [IDX_W-1:0] r_idx, w_idx_n;
  logic [TAG_W-1:0] r_tag, w_tag_n;
  logic [WAY_W-1:0] r_way, w_way_n;
  logic             r_inv_found, w_inv_found_n;
  logic [WAY_W-1:0] r_inv_way, w_inv_way_n;
  logic             r_rd_en, w_rd_en_n;
  logic [IDX_W-1:0] r_rd_index, w_rd_index_n;
  logic [WAY_W-1:0] r_rd_way, w_rd_way_n;
  logic             r_resp_valid, w_resp_valid_n;
  logic             r_resp_hit, w_resp_hit_n;
  logic [WAY_W-1:0] r_resp_way, w_resp_way_n;
  logic [WAY_W-1:0] r_rr_ptr [SETS];
  logic             w_rr_inc;
  logic             w_eq;
  logic             w_match;

  tag_comparator #(.W(TAG_W)) u_cmp (
    .a  (tag_rd_tag),
    .b  (r_tag),
    .eq (w_eq)
  );

  assign w_match      = tag_rd_vld & w_eq;
  assign req_ready    = (r_state == ST_IDLE);
  assign tag_rd_en    = r_rd_en;
  assign tag_rd_index = r_rd_index;
  assign tag_rd_way   = r_rd_way;
  assign resp_valid   = r_resp_valid;
  assign resp_hit     = r_resp_hit;
  assign resp_way     = r_resp_way;

  // State, datapath and registered-output update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_tag        <= '0;
      r_way        <= '0;
      r_inv_found  <= 1'b0;
      r_inv_way    <= '0;
      r_rd_en      <= 1'b0;
      r_rd_index   <= '0;
      r_rd_way     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_way   <= '0;
    end else begin
      r_state      <= w_state_n;
      r_idx        <= w_idx_n;
      r_tag        <= w_tag_n;
      r_way        <= w_way_n;
      r_inv_found  <= w_inv_found_n;
      r_inv_way    <= w_inv_way_n;
      r_rd_en      <= w_rd_en_n;
      r_rd_index   <= w_rd_index_n;
      r_rd_way     <= w_rd_way_n;
      r_resp_valid <= w_resp_valid_n;
      r_resp_hit   <= w_resp_hit_n;
      r_resp_way   <= w_resp_way_n;
    end
  end

  // Per-set round-robin victim pointers, advanced only by misses with no invalid way
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr_ptr[s] <= '0;
      end
    end else if (w_rr_inc) begin
      r_rr_ptr[r_idx] <= WAY_W'(r_rr_ptr[r_idx] + 1'b1);
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_n      = r_state;
    w_idx_n        = r_idx;
    w_tag_n        = r_tag;
    w_way_n        = r_way;
    w_inv_found_n  = r_inv_found;
    w_inv_way_n    = r_inv_way;
    w_rd_en_n      = 1'b0;
    w_rd_index_n   = r_rd_index;
    w_rd_way_n     = r_rd_way;
    w_resp_valid_n = r_resp_valid;
    w_resp_hit_n   = r_resp_hit;
    w_resp_way_n   = r_resp_way;
    w_rr_inc       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_idx_n       = req_index;
          w_tag_n       = req_tag;
          w_way_n       = '0;
          w_inv_found_n = 1'b0;
          w_rd_en_n     = 1'b1;
          w_rd_index_n  = req_index;
          w_rd_way_n    = '0;
          w_state_n     = ST_RD;
        end
      end

      ST_RD: begin
        w_state_n = ST_CMP;
      end

      ST_CMP: begin
        if (w_match) begin
          w_resp_hit_n   = 1'b1;
          w_resp_way_n   = r_way;
          w_resp_valid_n = 1'b1;
          w_state_n      = ST_RESP;
        end else begin
          if (!tag_rd_vld && !r_inv_found) begin
            w_inv_found_n = 1'b1;
            w_inv_way_n   = r_way;
          end
          if (r_way == LAST_WAY) begin
            // Victim: earliest invalid way (possibly this one), else round-robin
            w_resp_hit_n   = 1'b0;
            w_resp_valid_n = 1'b1;
            w_state_n      = ST_RESP;
            if (r_inv_found) begin
              w_resp_way_n = r_inv_way;
            end else if (!tag_rd_vld) begin
              w_resp_way_n = r_way;
            end else begin
              w_resp_way_n = r_rr_ptr[r_idx];
            end
          end else begin
            w_way_n    = WAY_W'(r_way + 1'b1);
            w_rd_en_n  = 1'b1;
            w_rd_way_n = WAY_W'(r_way + 1'b1);
            w_state_n  = ST_RD;
          end
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          w_resp_valid_n = 1'b0;
          w_state_n      = ST_IDLE;
          w_rr_inc       = !r_resp_hit && !r_inv_found;
        end
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed bench for tag_lookup_ctrl with a behavioural 1-cycle tag store.
module tb_tag_lookup_ctrl;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned SETS  = 16;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned WAY_W = 2;
  localparam int unsigned IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;
  logic             tag_rd_en;
  logic [IDX_W-1:0] tag_rd_index;
  logic [WAY_W-1:0] tag_rd_way;
  logic [TAG_W-1:0] tag_rd_tag;
  logic             tag_rd_vld;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_hit;
  logic [WAY_W-1:0] resp_way;

  logic [TAG_W-1:0] m_tag [SETS][WAYS];
  logic             m_vld [SETS][WAYS];
  int               rd_count = 0;
  int               n_assert = 0;
  int               n_fail   = 0;

  always #5 clk = ~clk;

  tag_lookup_ctrl #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_index    (req_index),
    .req_tag      (req_tag),
    .tag_rd_en    (tag_rd_en),
    .tag_rd_index (tag_rd_index),
    .tag_rd_way   (tag_rd_way),
    .tag_rd_tag   (tag_rd_tag),
    .tag_rd_vld   (tag_rd_vld),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_hit     (resp_hit),
    .resp_way     (resp_way)
  );

  // Tag store: data and valid appear the cycle after the read strobe
  always @(posedge clk) begin
    if (tag_rd_en) begin
      tag_rd_tag <= m_tag[tag_rd_index][tag_rd_way];
      tag_rd_vld <= m_vld[tag_rd_index][tag_rd_way];
      rd_count   <= rd_count + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_line(input int s, input logic [4*TAG_W-1:0] tags, input logic [3:0] vlds);
    for (int w = 0; w < 4; w++) begin
      m_tag[s][w] = tags[w*TAG_W +: TAG_W];
      m_vld[s][w] = vlds[w];
    end
  endtask

  // One complete request: accept, wait for response, optional backpressure, handshake
  task automatic lookup(input string name, input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                        input logic exp_hit, input int exp_way, input int exp_lat,
                        input int exp_rds, input int hold);
    int  cyc;
    int  rd0;
    bit  seen;
    @(negedge clk);
    chk({name, "_req_ready_idle"}, 32'(req_ready), 1);
    req_valid = 1'b1;
    req_index = idx;
    req_tag   = tag;
    @(posedge clk);
    rd0 = rd_count;
    #1;
    req_valid = 1'b0;
    req_index = ~idx;
    req_tag   = ~tag;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) seen = 1'b1;
    end
    chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({name, "_hit"}, 32'(resp_hit), 32'(exp_hit));
    chk({name, "_way"}, 32'(resp_way), 32'(exp_way));
    chk({name, "_rd_pulses"}, 32'(rd_count - rd0), 32'(exp_rds));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, 32'(resp_valid), 1);
      chk({name, "_hold_hit"}, 32'(resp_hit), 32'(exp_hit));
      chk({name, "_hold_way"}, 32'(resp_way), 32'(exp_way));
      chk({name, "_hold_req_ready"}, 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({name, "_idle_after"}, 32'(req_ready), 1);
    chk({name, "_valid_drop"}, 32'(resp_valid), 0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_index  = '0;
    req_tag    = '0;
    resp_ready = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      set_line(s, 32'h0000_0000, 4'b0000);
    end
    set_line(5, 32'h44_3C_22_11, 4'b1111);
    set_line(3, 32'h04_03_02_01, 4'b0101);
    set_line(7, 32'h73_72_71_70, 4'b1111);
    set_line(9, 32'h93_92_91_90, 4'b1111);
    set_line(2, 32'h3C_3C_55_3C, 4'b1110);

    // Reset values
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_tag_rd_en", 32'(tag_rd_en), 0);
    chk("rst_resp_hit", 32'(resp_hit), 0);
    chk("rst_resp_way", 32'(resp_way), 0);
    chk("rst_rd_index", 32'(tag_rd_index), 0);
    chk("rst_rd_way", 32'(tag_rd_way), 0);

    // Hit in way 2 after three reads
    lookup("hit_w2", 4'd5, 8'h3C, 1'b1, 2, 7, 3, 0);
    // Hit in the last way
    lookup("hit_w3", 4'd5, 8'h44, 1'b1, 3, 9, 4, 0);
    // Miss, first invalid way is 1
    lookup("miss_inv", 4'd3, 8'hAA, 1'b0, 1, 9, 4, 0);
    // Only the last way invalid: it becomes the victim
    set_line(3, 32'h04_03_02_01, 4'b0111);
    lookup("miss_inv_last", 4'd3, 8'hAA, 1'b0, 3, 9, 4, 0);
    // Set 3 pointer still at 0 after invalid-way misses
    set_line(3, 32'h04_03_02_01, 4'b1111);
    lookup("rr3_unchanged", 4'd3, 8'hAA, 1'b0, 0, 9, 4, 0);

    // Round-robin sequence with wrap on set 7
    lookup("rr7_0", 4'd7, 8'hEE, 1'b0, 0, 9, 4, 0);
    lookup("rr7_1", 4'd7, 8'hEE, 1'b0, 1, 9, 4, 0);
    lookup("rr7_2", 4'd7, 8'hEE, 1'b0, 2, 9, 4, 0);
    lookup("rr7_3", 4'd7, 8'hEE, 1'b0, 3, 9, 4, 0);
    lookup("rr7_wrap", 4'd7, 8'hEE, 1'b0, 0, 9, 4, 0);
    // Other set pointers unaffected
    lookup("rr9_indep", 4'd9, 8'hEE, 1'b0, 0, 9, 4, 0);

    // Backpressure on a hit in way 0
    lookup("bp_hit", 4'd5, 8'h11, 1'b1, 0, 3, 1, 4);

    // Matching tag with valid clear is skipped
    lookup("inv_match", 4'd2, 8'h3C, 1'b1, 2, 7, 3, 0);

    // Reset during a CMP cycle aborts the lookup
    @(negedge clk);
    req_valid = 1'b1;
    req_index = 4'd7;
    req_tag   = 8'hEE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_rd_en", 32'(tag_rd_en), 1);
    chk("abort_rd_index", 32'(tag_rd_index), 7);
    chk("abort_rd_way", 32'(tag_rd_way), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_req_ready", 32'(req_ready), 1);
    chk("abort_resp_valid", 32'(resp_valid), 0);
    chk("abort_tag_rd_en", 32'(tag_rd_en), 0);
    repeat (10) @(negedge clk);
    chk("abort_no_resp", 32'(resp_valid), 0);
    chk("abort_idle", 32'(req_ready), 1);
    // All pointers back to 0, lookups proceed normally
    lookup("post_rst_rr7", 4'd7, 8'hEE, 1'b0, 0, 9, 4, 0);
    lookup("post_rst_rr3", 4'd3, 8'hAA, 1'b0, 0, 9, 4, 0);
    lookup("post_rst_hit", 4'd5, 8'h22, 1'b1, 1, 5, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
